// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_ctrl                                               |
// | Brief    : Multicycle CPU control FSM with retired-instruction counter.  |
// |            Optional memory-handshake timeout via macro MEM_TIMEOUT_EN.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       functCode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IR_Enable,
  output logic             PC_Enable,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [4:0]       ALUOp,
  output logic [1:0]       ramType,
  output logic [2:0]       state,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;
  logic             w_is_load;
  logic             w_is_store;
  logic [1:0]       w_size;
  logic             w_wait_hit;
  logic             w_unused;

  assign w_unused = functCode[5];

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("multicycle_ctrl: TIMEOUT must be at least 1");
  end

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = 2'b00;
    case (OpCode)
      6'h23: begin w_is_load  = 1'b1; w_size = 2'b00; end
      6'h21: begin w_is_load  = 1'b1; w_size = 2'b01; end
      6'h20: begin w_is_load  = 1'b1; w_size = 2'b10; end
      6'h2B: begin w_is_store = 1'b1; w_size = 2'b00; end
      6'h29: begin w_is_store = 1'b1; w_size = 2'b01; end
      6'h28: begin w_is_store = 1'b1; w_size = 2'b10; end
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

  logic [c_WAIT_W-1:0] r_wait;
  logic                w_waiting;

  assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !MemReady;
  // The TIMEOUT-th consecutive stalled cycle is the last one before FAULT.
  assign w_wait_hit = w_waiting && ((int'(r_wait) + 1) >= TIMEOUT);

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_wait <= '0;
    end else if (w_waiting && !w_wait_hit) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  assign Fault = (r_state == S_FAULT);
`else
  assign w_wait_hit = 1'b0;
  assign Fault      = 1'b0;
`endif

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are gated by RESET so strobes drop the moment reset asserts.
  always_comb begin
    w_next    = r_state;
    IR_Enable = 1'b0;
    PC_Enable = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUOp     = 5'h00;
    ramType   = 2'b00;
    w_retire  = 1'b0;
    if (!RESET) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IR_Enable = 1'b1;
            PC_Enable = 1'b1;
            w_next    = S_DECODE;
          end else if (w_wait_hit) begin
            w_next = S_FAULT;
          end
        end
        S_DECODE: begin
          w_next = S_EXEC;
        end
        S_EXEC: begin
          if (OpCode == c_OP_RTYPE) begin
            ALUOp  = functCode[4:0];
            w_next = S_WB;
          end else if (w_is_load || w_is_store) begin
            ALUOp  = 5'h00;
            w_next = S_MEM;
          end else if (OpCode == c_OP_BEQ) begin
            ALUOp     = 5'h01;
            PC_Enable = Zero;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end
        S_MEM: begin
          MemRead  = w_is_load;
          MemWrite = w_is_store;
          ramType  = w_size;
          if (MemReady) begin
            w_next   = w_is_load ? S_WB : S_FETCH;
            w_retire = !w_is_load;
          end else if (w_wait_hit) begin
            w_next = S_FAULT;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        S_FAULT: begin
          w_next = S_FAULT;
        end
`endif
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign state      = r_state;
  assign InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multicycle_ctrl                                            |
// | Brief    : Scoreboard bench for multicycle_ctrl (timeout part needs      |
// |            MEM_TIMEOUT_EN).                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       RESET = 1'b1;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] functCode = 6'h00;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       IR_Enable, PC_Enable, RegWrite, MemRead, MemWrite;
  logic [4:0] ALUOp;
  logic [1:0] ramType;
  logic [2:0] state;
  logic       Fault;
  logic [3:0] InstrCount;

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT(15)) dut (
    .Clk(Clk), .RESET(RESET), .OpCode(OpCode), .functCode(functCode),
    .Zero(Zero), .MemReady(MemReady), .IR_Enable(IR_Enable),
    .PC_Enable(PC_Enable), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .ramType(ramType), .state(state),
    .Fault(Fault), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] st;
    logic [4:0] strb;   // {IR, PC, RegWrite, MemRead, MemWrite}
    logic [4:0] alu;
    logic [1:0] rt;
    logic [3:0] cnt;
    logic       flt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge Clk) begin
    exp_t        e;
    logic [19:0] act, want;
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      act  = {state, IR_Enable, PC_Enable, RegWrite, MemRead, MemWrite,
              ALUOp, ramType, InstrCount, Fault};
      want = {e.st, e.strb, e.alu, e.rt, e.cnt, e.flt};
      n_cmp++;
      if (act !== want) begin
        n_bad++;
        $display("FAIL %s: got st=%0d strb=%b alu=%h rt=%b cnt=%0d flt=%b, want st=%0d strb=%b alu=%h rt=%b cnt=%0d flt=%b",
                 e.tag, state, {IR_Enable, PC_Enable, RegWrite, MemRead, MemWrite},
                 ALUOp, ramType, InstrCount, Fault,
                 e.st, e.strb, e.alu, e.rt, e.cnt, e.flt);
      end
    end
  end

  // Drive one cycle of inputs and queue the response expected in that cycle.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic mr,
                      input logic [2:0] st, input logic [4:0] strb,
                      input logic [4:0] alu, input logic [1:0] rt,
                      input logic [3:0] cnt, input logic flt);
    exp_t e;
    RESET = rst; OpCode = op; functCode = fn; Zero = z; MemReady = mr;
    e.st = st; e.strb = strb; e.alu = alu; e.rt = rt; e.cnt = cnt;
    e.flt = flt; e.tag = tag;
    sb.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    step("reset_hold", 1, 6'h00, 6'h20, 0, 1, 3'd0, 5'b00000, 5'h00, 2'b00, 4'd0, 0);

    // R-type add: 0,1,2,4 then retire
    step("r1_fetch",  0, 6'h00, 6'h20, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd0, 0);
    step("r1_decode", 0, 6'h00, 6'h20, 0, 1, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd0, 0);
    step("r1_exec",   0, 6'h00, 6'h20, 0, 1, 3'd2, 5'b00000, 5'h00, 2'b00, 4'd0, 0);
    step("r1_wb",     0, 6'h00, 6'h20, 0, 1, 3'd4, 5'b00100, 5'h00, 2'b00, 4'd0, 0);
    // R-type with funct 0x25 -> ALUOp 0x05
    step("r2_fetch",  0, 6'h00, 6'h25, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd1, 0);
    step("r2_decode", 0, 6'h00, 6'h25, 0, 1, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd1, 0);
    step("r2_exec",   0, 6'h00, 6'h25, 0, 1, 3'd2, 5'b00000, 5'h05, 2'b00, 4'd1, 0);
    step("r2_wb",     0, 6'h00, 6'h25, 0, 1, 3'd4, 5'b00100, 5'h00, 2'b00, 4'd1, 0);
    // Load half with 3 wait states in MEM: 8 cycles total
    step("lh_fetch",  0, 6'h21, 6'h00, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd2, 0);
    step("lh_decode", 0, 6'h21, 6'h00, 0, 0, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd2, 0);
    step("lh_exec",   0, 6'h21, 6'h00, 0, 0, 3'd2, 5'b00000, 5'h00, 2'b00, 4'd2, 0);
    for (int i = 0; i < 3; i++)
      step("lh_mem_wait", 0, 6'h21, 6'h00, 0, 0, 3'd3, 5'b00010, 5'h00, 2'b01, 4'd2, 0);
    step("lh_mem_done", 0, 6'h21, 6'h00, 0, 1, 3'd3, 5'b00010, 5'h00, 2'b01, 4'd2, 0);
    step("lh_wb",     0, 6'h21, 6'h00, 0, 1, 3'd4, 5'b00100, 5'h00, 2'b00, 4'd2, 0);
    // Store word, zero wait states: 4 cycles
    step("sw_fetch",  0, 6'h2B, 6'h00, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd3, 0);
    step("sw_decode", 0, 6'h2B, 6'h00, 0, 1, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd3, 0);
    step("sw_exec",   0, 6'h2B, 6'h00, 0, 1, 3'd2, 5'b00000, 5'h00, 2'b00, 4'd3, 0);
    step("sw_mem",    0, 6'h2B, 6'h00, 0, 1, 3'd3, 5'b00001, 5'h00, 2'b00, 4'd3, 0);
    // BEQ taken then not taken
    step("beq1_fetch",  0, 6'h04, 6'h00, 1, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd4, 0);
    step("beq1_decode", 0, 6'h04, 6'h00, 1, 1, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd4, 0);
    step("beq1_exec",   0, 6'h04, 6'h00, 1, 1, 3'd2, 5'b01000, 5'h01, 2'b00, 4'd4, 0);
    step("beq0_fetch",  0, 6'h04, 6'h00, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd5, 0);
    step("beq0_decode", 0, 6'h04, 6'h00, 0, 1, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd5, 0);
    step("beq0_exec",   0, 6'h04, 6'h00, 0, 1, 3'd2, 5'b00000, 5'h01, 2'b00, 4'd5, 0);
    // Store byte: fetch stall, then reset in the middle of MEM
    step("sb_fetch_wait", 0, 6'h28, 6'h00, 0, 0, 3'd0, 5'b00010, 5'h00, 2'b00, 4'd6, 0);
    step("sb_fetch",  0, 6'h28, 6'h00, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd6, 0);
    step("sb_decode", 0, 6'h28, 6'h00, 0, 0, 3'd1, 5'b00000, 5'h00, 2'b00, 4'd6, 0);
    step("sb_exec",   0, 6'h28, 6'h00, 0, 0, 3'd2, 5'b00000, 5'h00, 2'b00, 4'd6, 0);
    step("sb_mem_wait", 0, 6'h28, 6'h00, 0, 0, 3'd3, 5'b00001, 5'h00, 2'b10, 4'd6, 0);
    step("sb_reset",  1, 6'h28, 6'h00, 0, 0, 3'd0, 5'b00000, 5'h00, 2'b00, 4'd0, 0);
    // 16 NOPs wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      step("nop_fetch",  0, 6'h3F, 6'h00, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, i[3:0], 0);
      step("nop_decode", 0, 6'h3F, 6'h00, 0, 1, 3'd1, 5'b00000, 5'h00, 2'b00, i[3:0], 0);
      step("nop_exec",   0, 6'h3F, 6'h00, 0, 1, 3'd2, 5'b00000, 5'h00, 2'b00, i[3:0], 0);
    end
    step("wrap_check", 0, 6'h3F, 6'h00, 0, 0, 3'd0, 5'b00010, 5'h00, 2'b00, 4'd0, 0);
`ifdef MEM_TIMEOUT_EN
    // wrap_check was stall cycle 1 of 15; FAULT follows the 15th
    for (int i = 0; i < 14; i++)
      step("to_wait", 0, 6'h3F, 6'h00, 0, 0, 3'd0, 5'b00010, 5'h00, 2'b00, 4'd0, 0);
    step("to_fault",  0, 6'h3F, 6'h00, 0, 0, 3'd5, 5'b00000, 5'h00, 2'b00, 4'd0, 1);
    step("to_absorb", 0, 6'h3F, 6'h00, 0, 1, 3'd5, 5'b00000, 5'h00, 2'b00, 4'd0, 1);
    step("to_absorb", 0, 6'h00, 6'h20, 0, 1, 3'd5, 5'b00000, 5'h00, 2'b00, 4'd0, 1);
    step("to_reset",  1, 6'h00, 6'h20, 0, 1, 3'd0, 5'b00000, 5'h00, 2'b00, 4'd0, 0);
    step("to_refetch", 0, 6'h00, 6'h20, 0, 1, 3'd0, 5'b11010, 5'h00, 2'b00, 4'd0, 0);
`endif
    @(posedge Clk);
    @(negedge Clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
